light_table_loader: RTL
=======================

Name: light_table_loader

Overview:
- Writer side of the light-table double buffer: turns a host byte stream into staging-buffer (L2) write transactions and commit (flush) pulses.
- Sits between the host link (UART/SPI byte deframer) and the light table that feeds the tracer.
- Assembles 24-byte light records (pos x,y,z, col r,g,b; Q8.24) and issues one-cycle L2 writes.
- Holds off new traffic while the table copies L2 to L1.

Parameters:
- NUM_LIGHTS, 8, number of light slots; ID_W = 3.
- REC_BYTES, 24, payload bytes per record (6 x 32-bit words).
- L2_W, 289, width of the l2_write bus; bits above 191 are driven 0.
- FLUSH_HOLDOFF, 18, cycles in_ready stays low after a flush pulse; must be at least 2*NUM_LIGHTS+2.
- TIMEOUT, 1024, maximum idle cycles between payload bytes before the partial record is dropped.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  byte-stream valid
- in_data  in  8  byte-stream data
- in_ready  out  1  byte accepted when in_valid && in_ready
- l2_write_enable  out  1  one-cycle L2 write strobe
- l2_write_id  out  3  target light slot
- l2_write  out  289  record; [191:0] payload, [288:192] = 0
- l2_flush_to_l1  out  1  one-cycle commit pulse
- busy  out  1  high in any state other than IDLE
- err_count  out  8  saturating protocol-error counter
- written_mask  out  8  slots written since the last commit

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, in_ready=0 while rst_n is low.
  - All outputs are 0; the partial record is discarded.
  - in_ready rises in the first cycle after rst_n deasserts.
- Framing:
  - Header byte 0x00-0x07 = WRITE to slot hdr[2:0]; it is followed by REC_BYTES payload bytes.
  - Header 0x80 = COMMIT.
  - Any other header is an error: err_count++ (saturates at 255), state stays IDLE.
- Payload packing, little-endian:
  - Payload byte k lands in l2_write[8k+7:8k].
  - Word order is pos x [31:0], pos y [63:32], pos z [95:64], col r [127:96], col g [159:128], col b [191:160].
- States:
  - IDLE: in_ready=1. An accepted header latches id and goes to PAYLOAD (WRITE header) or FLUSH (COMMIT).
  - PAYLOAD: in_ready=1; byte counter runs 0..23 and the idle timer resets on each accepted byte. The 24th accepted byte goes to WRITE. If the timer reaches TIMEOUT, the record is dropped, err_count++, and the state returns to IDLE with no write.
  - WRITE (1 cycle): in_ready=0, l2_write_enable=1, l2_write_id and l2_write valid, written_mask[id] set. Next state IDLE.
  - FLUSH (1 cycle): in_ready=0, l2_flush_to_l1=1, written_mask cleared. Next state HOLD.
  - HOLD: in_ready=0 for FLUSH_HOLDOFF cycles (counter FLUSH_HOLDOFF-1 down to 0), then IDLE.
- Latency:
  - Last payload byte accepted at edge N: write strobe is visible in cycle N+1.
  - COMMIT accepted at edge N: flush pulse in cycle N+1; in_ready returns high at cycle N+2+FLUSH_HOLDOFF.
- Output stability: l2_write and l2_write_id stay stable from the WRITE cycle until the next payload byte is accepted. Strobes are never asserted together.
- Boundaries:
  - in_valid low during PAYLOAD only advances the timer; a byte accepted in the same cycle the timer reaches TIMEOUT is taken and the timer reset (byte wins).
  - Back-to-back packets are allowed: the next header is accepted in the cycle after WRITE.
  - COMMIT with written_mask=0 still pulses the flush.
  - Reset mid-PAYLOAD or mid-HOLD returns to IDLE with no strobe emitted.
  - err_count holds at 255.

Decomposition:
- Package light_link_pkg holds:
  - Constants: REC_BYTES, CMD_COMMIT=8'h80, CMD_WRITE_MASK=8'hF8, LIGHT_REC_W=192.
  - Field offsets: POS_X/Y/Z, COL_R/G/B.
  - State enum.
- Sub-module light_rec_shifter:
  - 192-bit byte-indexed record register with a 5-bit byte counter.
  - Signals: load, clear, done.
- FSM, timers and counters live in light_table_loader.

Test Plan:
- Send 0x01 then bytes 0x00,0x00,0x00,0x01, 0x00,0x00,0x00,0x03, 4x0x00, 0x00,0x00,0x00,0x01 x3 -> exactly one cycle with l2_write_enable=1, id=1, l2_write[191:0] = {3x32'h01000000, 32'h0, 32'h03000000, 32'h01000000}, upper bits 0, written_mask=8'h02.
- Header 0x80 -> l2_flush_to_l1 high for exactly one cycle one cycle after acceptance; in_ready low for 19 cycles (18 HOLD + 1 FLUSH); written_mask=0.
- Headers 0x08, 0x7F, 0xFF -> err_count=3, no strobes, in_ready stays 1. Then 300 bad headers -> err_count=255.
- WRITE header plus 10 payload bytes, then in_valid low for 1024 cycles -> no write, err_count+1, IDLE. A fresh full packet then writes correctly.
- rst_n pulsed low asynchronously mid-payload (byte 12) -> outputs 0 immediately, no write strobe. A full packet after release writes correctly.
- Back-to-back writes to slots 7 and 0 with in_valid held high -> two strobes 26 cycles apart (25 bytes + 1 WRITE cycle), written_mask=8'h81.

Source files
------------

// File: rtl/light_link_pkg.sv
// Shared constants, record field offsets and FSM state type for the light-table host link.
package light_link_pkg;

  localparam int REC_BYTES   = 24;
  localparam int LIGHT_REC_W = 8 * REC_BYTES;

  localparam logic [7:0] CMD_COMMIT     = 8'h80;
  localparam logic [7:0] CMD_WRITE_MASK = 8'hF8;

  // Bit offsets of the Q8.24 words inside a packed light record
  localparam int POS_X = 0;
  localparam int POS_Y = 32;
  localparam int POS_Z = 64;
  localparam int COL_R = 96;
  localparam int COL_G = 128;
  localparam int COL_B = 160;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PAYLOAD,
    ST_WRITE,
    ST_FLUSH,
    ST_HOLD
  } state_t;

endpackage

// File: rtl/light_rec_shifter.sv
// Byte-indexed light record register: payload byte k lands in rec[8k+7:8k].
module light_rec_shifter
  import light_link_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic                   clear,
  input  logic [7:0]             din,
  output logic                   done,
  output logic [LIGHT_REC_W-1:0] rec
);

  logic [4:0] cnt;

  assign done = load && (cnt == 5'(REC_BYTES - 1));

  // NOTE: the record is a plain register, not a RAM, so it takes the async
  // reset; that keeps l2_write at zero while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      rec <= '0;
    end else if (clear) begin
      // Only the counter restarts; the last record stays visible on l2_write.
      cnt <= '0;
    end else if (load) begin
      for (int k = 0; k < REC_BYTES; k++) begin
        if (cnt == 5'(k)) rec[8*k +: 8] <= din;
      end
      cnt <= done ? 5'd0 : cnt + 5'd1;
    end
  end

endmodule

// File: rtl/light_table_loader.sv
// Host byte stream to light-table L2 writes and L2->L1 commit pulses,
// with a holdoff while the table performs its copy.
module light_table_loader
  import light_link_pkg::*;
#(
  parameter int NUM_LIGHTS    = 8,
  parameter int L2_W          = 289,
  parameter int FLUSH_HOLDOFF = 18,
  parameter int TIMEOUT       = 1024,
  localparam int ID_W         = $clog2(NUM_LIGHTS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  l2_write_enable,
  output logic [ID_W-1:0]       l2_write_id,
  output logic [L2_W-1:0]       l2_write,
  output logic                  l2_flush_to_l1,
  output logic                  busy,
  output logic [7:0]            err_count,
  output logic [NUM_LIGHTS-1:0] written_mask
);

  localparam int TIMER_W = $clog2(TIMEOUT);
  localparam int HOLD_W  = $clog2(FLUSH_HOLDOFF);

  state_t                 state;
  logic [TIMER_W-1:0]     timer;
  logic [HOLD_W-1:0]      hold_cnt;
  logic                   accept;
  logic                   rec_done;
  logic [LIGHT_REC_W-1:0] rec;

  assign accept = in_valid && in_ready;
  assign busy   = (state != ST_IDLE);

  light_rec_shifter u_shifter (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept && state == ST_PAYLOAD),
    .clear (state != ST_PAYLOAD),
    .din   (in_data),
    .done  (rec_done),
    .rec   (rec)
  );

  assign l2_write = {{(L2_W - LIGHT_REC_W){1'b0}}, rec};

  // Outputs are registered: each is set on the edge that enters the state
  // in which it must be visible.
  // NOTE: all state here is assigned with <= so every branch sees the values
  // from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      in_ready        <= 1'b0;
      l2_write_enable <= 1'b0;
      l2_write_id     <= '0;
      l2_flush_to_l1  <= 1'b0;
      err_count       <= '0;
      written_mask    <= '0;
      timer           <= '0;
      hold_cnt        <= '0;
    end else begin
      l2_write_enable <= 1'b0;
      l2_flush_to_l1  <= 1'b0;
      case (state)
        ST_IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            if ((in_data & CMD_WRITE_MASK) == 8'h00) begin
              l2_write_id <= in_data[ID_W-1:0];
              timer       <= '0;
              state       <= ST_PAYLOAD;
            end else if (in_data == CMD_COMMIT) begin
              in_ready       <= 1'b0;
              l2_flush_to_l1 <= 1'b1;
              written_mask   <= '0;
              state          <= ST_FLUSH;
            end else if (err_count != 8'hFF) begin
              err_count <= err_count + 8'd1;
            end
          end
        end
        ST_PAYLOAD: begin
          if (accept) begin
            timer <= '0;
            if (rec_done) begin
              in_ready                  <= 1'b0;
              l2_write_enable           <= 1'b1;
              written_mask[l2_write_id] <= 1'b1;
              state                     <= ST_WRITE;
            end
          end else if (timer == TIMER_W'(TIMEOUT - 1)) begin
            // Host stalled mid-record: drop the partial record.
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            state <= ST_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_WRITE: begin
          in_ready <= 1'b1;
          state    <= ST_IDLE;
        end
        ST_FLUSH: begin
          hold_cnt <= HOLD_W'(FLUSH_HOLDOFF - 1);
          state    <= ST_HOLD;
        end
        ST_HOLD: begin
          if (hold_cnt == '0) begin
            in_ready <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: begin
          in_ready <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
